// File: rtl/synth_pkg.sv
// Shared NCO constants, state encoding and the 32-entry sine wavetable.
// Build option: define NCO_INTERP_EN for linear interpolation between entries.
package synth_pkg;

    localparam int PHASE_W   = 32;
    localparam int IDX_W     = 5;
    localparam int SAMPLE_W  = 16;
    localparam int FRAC_W    = 16;
    localparam int LUT_DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } nco_state_t;

    typedef logic [PHASE_W-1:0]         phase_t;
    typedef logic [IDX_W-1:0]           idx_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // round(32767 * sin(2*pi*k/32))
    localparam sample_t SINE_LUT [LUT_DEPTH] = '{
        16'sd0,      16'sd6393,   16'sd12539,  16'sd18204,
        16'sd23170,  16'sd27245,  16'sd30273,  16'sd32137,
        16'sd32767,  16'sd32137,  16'sd30273,  16'sd27245,
        16'sd23170,  16'sd18204,  16'sd12539,  16'sd6393,
        16'sd0,      -16'sd6393,  -16'sd12539, -16'sd18204,
        -16'sd23170, -16'sd27245, -16'sd30273, -16'sd32137,
        -16'sd32767, -16'sd32137, -16'sd30273, -16'sd27245,
        -16'sd23170, -16'sd18204, -16'sd12539, -16'sd6393
    };

    function automatic idx_t idx_next(input idx_t i);
        return i + idx_t'(1);
    endfunction

    function automatic idx_t phase_idx(input phase_t p);
        return p[PHASE_W-1 -: IDX_W];
    endfunction

endpackage

// File: rtl/sine_lut_32.sv
// Combinational dual-read sine wavetable: entry idx and its wrapped successor.
// The successor read feeds the NCO_INTERP_EN interpolation path.
module sine_lut_32
    import synth_pkg::*;
(
    input  logic [IDX_W-1:0]           idx,
    output logic signed [SAMPLE_W-1:0] a,
    output logic signed [SAMPLE_W-1:0] b
);

    always_comb begin
        a = SINE_LUT[idx];
        b = SINE_LUT[idx_next(idx)];
    end

endmodule

// File: rtl/nco_phase_accumulator.sv
// Tick-driven 32-bit phase accumulator with click-free release into a sine wavetable.
// Build option: NCO_INTERP_EN adds linear interpolation and one extra output stage.
module nco_phase_accumulator
    import synth_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic [PHASE_W-1:0]         nco_increment_value,
    input  logic                       nco_mute,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       nco_active
);

    nco_state_t           state_q;
    nco_state_t           state_d;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   phase_d;
    logic [PHASE_W:0]     phase_sum;
    logic                 carry;
    logic [IDX_W-1:0]     lut_idx;
    sample_t              lut_a;
    sample_t              lut_b;
    logic                 quiet;

    assign phase_sum = {1'b0, phase_q} + {1'b0, nco_increment_value};
    assign carry     = phase_sum[PHASE_W];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!nco_mute) begin
                        state_d = RUN;
                        phase_d = phase_sum[PHASE_W-1:0];
                    end else begin
                        phase_d = '0;
                    end
                end
                RUN: begin
                    phase_d = phase_sum[PHASE_W-1:0];
                    if (nco_mute) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    // Unmute wins over wrap so the waveform never jumps.
                    if (!nco_mute) begin
                        state_d = RUN;
                        phase_d = phase_sum[PHASE_W-1:0];
                    end else if (carry) begin
                        state_d = IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_sum[PHASE_W-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    assign nco_active = (state_q != IDLE);
    assign lut_idx    = phase_idx(phase_q);
    assign quiet      = (state_q == IDLE);

    sine_lut_32 u_lut (
        .idx (lut_idx),
        .a   (lut_a),
        .b   (lut_b)
    );

`ifdef NCO_INTERP_EN
    logic                      s1_valid;
    sample_t                   s1_a;
    logic signed [SAMPLE_W:0]  s1_diff;
    logic [FRAC_W-1:0]         s1_frac;
    logic [2*SAMPLE_W+1:0]     prod;
    logic [SAMPLE_W-1:0]       step;
    logic                      unused_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_diff  <= '0;
            s1_frac  <= '0;
        end else begin
            s1_valid <= sample_tick;
            if (sample_tick) begin
                s1_a    <= quiet ? '0 : lut_a;
                s1_diff <= quiet ? '0 :
                           ({lut_b[SAMPLE_W-1], lut_b} -
                            {lut_a[SAMPLE_W-1], lut_a});
                s1_frac <= phase_q[PHASE_W-IDX_W-1 -: FRAC_W];
            end
        end
    end

    // Two's-complement product modulo 2^34 is exact for a 17x16 operand pair.
    assign prod = {{(SAMPLE_W+1){s1_diff[SAMPLE_W]}}, s1_diff} *
                  {{(SAMPLE_W+2){1'b0}}, s1_frac};
    assign step = prod[FRAC_W +: SAMPLE_W];
    assign unused_prod = ^{prod[2*SAMPLE_W+1:FRAC_W+SAMPLE_W],
                           prod[FRAC_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            sample_out   <= '0;
        end else begin
            sample_valid <= s1_valid;
            if (s1_valid) begin
                sample_out <= s1_a + $signed(step);
            end
        end
    end
`else
    logic unused_b;

    assign unused_b = ^lut_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            sample_out   <= '0;
        end else begin
            sample_valid <= sample_tick;
            if (sample_tick) begin
                sample_out <= quiet ? '0 : lut_a;
            end
        end
    end
`endif

endmodule
